// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, addresses IMEM and buffers {pc, instruction} pairs for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target halts fetch.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data,
   input  logic        imem_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        fetch_misaligned
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   entry_t           buffer [FIFO_DEPTH];
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic             halted_q, halted_d;
   logic             valid_q, valid_d;
   logic             misaligned_q, misaligned_d;
   entry_t           head_q, head_d;
   logic             pop_c, push_c, bad_target_c;
   entry_t           fetched_c;

   // Next-state logic; the head is precomputed so decode sees only registered values.
   always_comb begin
      bad_target_c = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      bad_target_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
      fetched_c    = '{pc: pc_q, word: imem_data};
      pop_c        = valid_q && instr_ready;
      push_c       = imem_valid && !redirect_valid && !halted_q &&
                     ((count_q < CNT_W'(FIFO_DEPTH)) || pop_c);
      pc_d         = pc_q;
      count_d      = count_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      halted_d     = halted_q;
      misaligned_d = bad_target_c;

      if (redirect_valid) begin
         // Flush wins over any same-cycle pop or push
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
         pc_d    = bad_target_c ? redirect_pc : {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
         halted_d = bad_target_c;
`endif
      end else begin
         if (push_c) begin
            wr_d = wr_q + PTR_W'(1);
            pc_d = pc_q + 32'd4;
         end
         if (pop_c) begin
            rd_d = rd_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end

      valid_d = (count_d != '0);
      head_d  = '{pc: 32'h0, word: NOP};
      if (valid_d) begin
         // Entry being written this edge becomes the head when the buffer is otherwise empty
         head_d = (push_c && (wr_q == rd_d)) ? fetched_c : buffer[rd_d];
      end
   end

   always_ff @(posedge clock) begin
      if (push_c) begin
         buffer[wr_q] <= fetched_c;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q         <= RESET_VECTOR;
         count_q      <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         halted_q     <= 1'b0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         head_q       <= '{pc: 32'h0, word: NOP};
      end else begin
         pc_q         <= pc_d;
         count_q      <= count_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         halted_q     <= halted_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         head_q       <= head_d;
      end
   end

   assign imem_address     = pc_q;
   assign instr_valid      = valid_q;
   assign instr            = head_q.word;
   assign instr_pc         = head_q.pc;
   assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an expected-PC scoreboard drained by a delivery monitor.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic [31:0] imem_address;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_misaligned;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] t4_addr [6];

   fetch_unit #(
      .RESET_VECTOR(32'h0000_0100),
      .FIFO_DEPTH  (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_address    (imem_address),
      .imem_data       (imem_data),
      .imem_valid      (imem_valid),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .fetch_misaligned(fetch_misaligned)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_data = word_at(imem_address);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Delivery monitor: every accepted (not flushed) head must match the scoreboard front
   always @(negedge clock) begin
      if (reset && instr_valid && instr_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h expected nothing", instr_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("deliver_pc", instr_pc, e);
            check("deliver_instr", instr, word_at(e));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || instr_valid) && n < 40) begin
         step();
         n++;
      end
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_idle"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      t4_addr        = '{32'h44, 32'h44, 32'h48, 32'h48, 32'h4C, 32'h4C};
      reset          = 1'b1;
      imem_valid     = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #2 reset = 1'b0;
      step();
      step();
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_addr", imem_address, 32'h100);
      check("rst_misalign", 32'(fetch_misaligned), 32'd0);

      // Streaming from reset vector
      imem_valid  = 1'b1;
      instr_ready = 1'b1;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      exp_q.push_back(32'h108);
      reset = 1'b1;
      step();
      check("t1_first", instr_pc, 32'h100);
      step();
      check("t1_second", instr_pc, 32'h104);
      step();
      check("t1_third", instr_pc, 32'h108);
      imem_valid = 1'b0;
      drain("t1");

      // Back-pressure: buffer fills to two entries and holds
      instr_ready = 1'b0;
      redirect(32'h0);
      imem_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_pc", instr_pc, 32'h0);
         check("t2_hold_instr", instr, word_at(32'h0));
      end
      check("t2_pc_held", imem_address, 32'h8);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      instr_ready = 1'b1;
      step();
      imem_valid = 1'b0;
      check("t2_next", instr_pc, 32'h4);
      step();
      check("t2_last", instr_pc, 32'h8);
      drain("t2");

      // Redirect while full with a pop in the same cycle
      instr_ready = 1'b0;
      imem_valid  = 1'b0;
      redirect(32'h10);
      imem_valid = 1'b1;
      step();
      step();
      step();
      check("t3_full_addr", imem_address, 32'h18);
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      redirect_valid = 1'b0;
      check("t3_flushed", 32'(instr_valid), 32'd0);
      check("t3_addr", imem_address, 32'h200);
      exp_q.push_back(32'h200);
      step();
      check("t3_target", instr_pc, 32'h200);
      imem_valid = 1'b0;
      drain("t3");

      // Gapped IMEM
      redirect(32'h40);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      exp_q.push_back(32'h48);
      for (int i = 0; i < 6; i++) begin
         imem_valid = (i % 2 == 0);
         step();
         check("t4_addr", imem_address, t4_addr[i]);
      end
      imem_valid = 1'b0;
      drain("t4");

      // PC wrap
      redirect(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      imem_valid = 1'b1;
      step();
      step();
      check("t5_wrap_addr", imem_address, 32'h0);
      step();
      check("t5_wrap_pc", instr_pc, 32'h0);
      check("t5_addr", imem_address, 32'h4);
      imem_valid = 1'b0;
      drain("t5");

      // Misaligned redirect
      redirect(32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("t6_pulse", 32'(fetch_misaligned), 32'd1);
      check("t6_addr", imem_address, 32'h202);
      imem_valid = 1'b1;
      step();
      check("t6_pulse_end", 32'(fetch_misaligned), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_halted_valid", 32'(instr_valid), 32'd0);
         check("t6_halted_addr", imem_address, 32'h202);
      end
      redirect(32'h300);
      exp_q.push_back(32'h300);
      step();
      check("t6_resume", instr_pc, 32'h300);
`else
      check("t6_addr", imem_address, 32'h200);
      check("t6_no_flag", 32'(fetch_misaligned), 32'd0);
      exp_q.push_back(32'h200);
      imem_valid = 1'b1;
      step();
      check("t6_resume", instr_pc, 32'h200);
`endif
      imem_valid = 1'b0;
      drain("t6");

      // Reset mid-operation discards buffered entries
      instr_ready = 1'b0;
      redirect(32'h500);
      imem_valid = 1'b1;
      step();
      step();
      check("t7_setup", 32'(instr_valid), 32'd1);
      reset = 1'b0;
      #1;
      check("t7_valid", 32'(instr_valid), 32'd0);
      check("t7_instr", instr, 32'h0000_0013);
      check("t7_pc", instr_pc, 32'h0);
      check("t7_addr", imem_address, 32'h100);
      step();
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      instr_ready = 1'b1;
      reset       = 1'b1;
      step();
      check("t7_first", instr_pc, 32'h100);
      step();
      imem_valid = 1'b0;
      drain("t7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
